mv_operand_loader: RTL and testbench
====================================

# mv_operand_loader

Streaming operand loader for the systolic matrix-vector multiplier. It accepts one frame of signed int8 elements over a valid/ready stream: first the SIZE vector elements, then the SIZE×SIZE matrix in row-major order. It assembles them into the parallel `in_vector`/`matrix` registers that drive the multiplier. It then holds the operands stable for the multiplier's pipeline latency and pulses `res_strobe` when the multiplier output is valid to capture.

## Interface
- `WIDTH`, 8: element width in bits (signed).
- `SIZE`, 64: vector length and matrix dimension.
- `LATENCY`, 3: cycles from operands valid to multiplier result valid; legal range is 1..15.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-high reset.
- `s_valid`  in  1  stream element valid.
- `s_ready`  out  1  loader can accept an element.
- `s_data`  in  WIDTH  signed element.
- `s_last`  in  1  marks the final element of a frame.
- `in_vector`  out  WIDTH×SIZE  assembled vector, element j.
- `matrix`  out  WIDTH×SIZE×SIZE  assembled matrix, [row][col].
- `op_valid`  out  1  operands complete and stable.
- `res_strobe`  out  1  one-cycle pulse; multiplier result valid this cycle.
- `frame_err`  out  1  one-cycle pulse; frame length / `s_last` mismatch.

## Operation
- Only one clock (`clk`); reset is asynchronous and active-high (`rst`).
- States: LOAD_VEC, LOAD_MAT, HOLD.
- Reset values:
  - state = LOAD_VEC; all counters = 0.
  - `s_ready` = 1.
  - `op_valid` = 0, `res_strobe` = 0, `frame_err` = 0.
  - all `in_vector` and `matrix` elements = 0.
- Accept = `s_valid && s_ready`, sampled at the rising edge.
- LOAD_VEC: each accept writes `in_vector[vidx]` and increments `vidx` (0..SIZE-1). The accept at `vidx == SIZE-1` moves the block to LOAD_MAT with `row = col = 0`.
- LOAD_MAT: each accept writes `matrix[row][col]`. `col` increments and wraps at SIZE-1, at which point `row` increments. The accept at `row == col == SIZE-1` moves the block to HOLD.
- HOLD:
  - `s_ready` = 0 and `op_valid` = 1.
  - A latency counter counts up from 0.
  - `res_strobe` is asserted in the cycle where the counter equals LATENCY-1.
  - On the edge ending that cycle the block returns to LOAD_VEC, clears the counters, and drops `op_valid`.
- Operand registers are written only on accepts. They keep their previous contents between frames and during HOLD.
- Framing rules, evaluated on every accept:
  - `s_last` = 1 on any element other than element SIZE+SIZE²-1: pulse `frame_err`, return to LOAD_VEC, and clear the indices. The written element is kept, but the frame is void and HOLD is not entered.
  - `s_last` = 0 on the final element: pulse `frame_err`, return to LOAD_VEC. HOLD is not entered.
- `s_valid` low stalls loading indefinitely with no state change. `s_data` and `s_last` are ignored when no accept occurs.
- Reset asserted mid-frame or mid-HOLD immediately forces all reset values. The partial frame is discarded and no strobe is issued.

## Timing
- `s_ready` is a registered function of state: high in LOAD_VEC/LOAD_MAT, low in HOLD.
- Throughput: one element per cycle with no bubbles inside a frame.
- Let the final accept occur at edge N:
  - `op_valid` = 1 from cycle N+1.
  - `res_strobe` = 1 in cycle N+LATENCY only.
  - `op_valid` = 0 and `s_ready` = 1 from cycle N+LATENCY+1.
- Minimum frame period is SIZE+SIZE²+LATENCY cycles.
- `frame_err` is high in the single cycle following the offending accept. `s_ready` stays high through it.
- `op_valid` and `res_strobe` are never high in the same cycle as `frame_err`.

## Test plan
All scenarios use SIZE=2, LATENCY=3.
1. **Nominal frame:** reset, then stream 1, 2, -3, 4, 5, -6 on consecutive cycles with `s_last` on -6 → `in_vector` = {1, 2}, `matrix` = {{-3, 4}, {5, -6}}; `op_valid` high 3 cycles; `res_strobe` pulses once in the 3rd HOLD cycle; `s_ready` low exactly 3 cycles.
2. **Stalls:** same frame with `s_valid` dropped for 2 cycles after element 2 and after element 4 → identical final operands; `op_valid` rises one cycle after the final accept.
3. **Early `s_last`:** `s_last` set on element 4 (value 4) → `frame_err` one pulse; `op_valid` stays 0; the next clean frame 7, 8, 9, 10, 11, 12 loads correctly and strobes.
4. **Missing `s_last`:** 6 elements with no `s_last` → `frame_err` pulse, no HOLD, `s_ready` remains 1.
5. **Reset mid-HOLD:** assert `rst` in the 2nd HOLD cycle → all outputs 0 immediately; no `res_strobe`; `s_ready` = 1 after release.
6. **Back-to-back frames:** two frames with `s_valid` held high, where the source keeps `s_data` on the first element of frame 2 while `s_ready` is low → frame 2 accepted from cycle N+4; second `res_strobe` exactly 9 cycles after the first; extremes -128 and 127 preserved in the operand registers.

Source files
------------

// File: rtl/mv_operand_loader.sv
// mv_operand_loader: collects one frame of signed elements from a valid/ready
// stream (vector first, then the matrix row-major) into the parallel operand
// registers of the systolic matrix-vector multiplier. The operands are then
// held for the multiplier latency and a one-cycle capture strobe is issued.
module mv_operand_loader #(
    parameter int WIDTH   = 8,
    parameter int SIZE    = 64,
    parameter int LATENCY = 3
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic                                    s_valid,
    output logic                                    s_ready,
    input  logic signed [WIDTH-1:0]                 s_data,
    input  logic                                    s_last,
    output logic [SIZE-1:0][WIDTH-1:0]              in_vector,
    output logic [SIZE-1:0][SIZE-1:0][WIDTH-1:0]    matrix,
    output logic                                    op_valid,
    output logic                                    res_strobe,
    output logic                                    frame_err
);

    localparam int IDX_W = (SIZE > 1) ? $clog2(SIZE) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SIZE - 1);
    localparam logic [3:0]       LAST_LAT = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        LOAD_VEC = 2'd0,
        LOAD_MAT = 2'd1,
        HOLD     = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [IDX_W-1:0] vidx;
    logic [IDX_W-1:0] vidx_next;
    logic [IDX_W-1:0] row;
    logic [IDX_W-1:0] row_next;
    logic [IDX_W-1:0] col;
    logic [IDX_W-1:0] col_next;
    logic [3:0]       lat_cnt;
    logic [3:0]       lat_next;
    logic             err_next;
    logic             accept;
    logic             is_final;

    // Handshake and status outputs are decoded straight from registered state,
    // so they never depend combinationally on the stream inputs.
    assign s_ready    = (state != HOLD);
    assign op_valid   = (state == HOLD);
    assign res_strobe = (state == HOLD) && (lat_cnt == LAST_LAT);
    assign accept     = s_valid && s_ready;
    assign is_final   = (state == LOAD_MAT) && (row == LAST_IDX) && (col == LAST_IDX);

    // State, index counters, latency counter and the error pulse register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= LOAD_VEC;
            vidx      <= '0;
            row       <= '0;
            col       <= '0;
            lat_cnt   <= '0;
            frame_err <= 1'b0;
        end else begin
            state     <= state_next;
            vidx      <= vidx_next;
            row       <= row_next;
            col       <= col_next;
            lat_cnt   <= lat_next;
            frame_err <= err_next;
        end
    end

    // Next-state logic: walk the indices on every accept, police s_last framing,
    // and count out the hold window before returning to vector loading.
    always_comb begin
        state_next = state;
        vidx_next  = vidx;
        row_next   = row;
        col_next   = col;
        lat_next   = lat_cnt;
        err_next   = 1'b0;
        case (state)
            LOAD_VEC: begin
                if (accept) begin
                    if (s_last) begin
                        // The last element of a frame is always a matrix element.
                        err_next   = 1'b1;
                        state_next = LOAD_VEC;
                        vidx_next  = '0;
                        row_next   = '0;
                        col_next   = '0;
                    end else if (vidx == LAST_IDX) begin
                        state_next = LOAD_MAT;
                        vidx_next  = '0;
                        row_next   = '0;
                        col_next   = '0;
                    end else begin
                        vidx_next = vidx + IDX_W'(1);
                    end
                end
            end
            LOAD_MAT: begin
                if (accept) begin
                    if (s_last != is_final) begin
                        err_next   = 1'b1;
                        state_next = LOAD_VEC;
                        vidx_next  = '0;
                        row_next   = '0;
                        col_next   = '0;
                    end else if (is_final) begin
                        state_next = HOLD;
                        row_next   = '0;
                        col_next   = '0;
                        lat_next   = '0;
                    end else if (col == LAST_IDX) begin
                        col_next = '0;
                        row_next = row + IDX_W'(1);
                    end else begin
                        col_next = col + IDX_W'(1);
                    end
                end
            end
            HOLD: begin
                if (lat_cnt == LAST_LAT) begin
                    state_next = LOAD_VEC;
                    lat_next   = '0;
                    vidx_next  = '0;
                    row_next   = '0;
                    col_next   = '0;
                end else begin
                    lat_next = lat_cnt + 4'd1;
                end
            end
            default: begin
                state_next = LOAD_VEC;
                vidx_next  = '0;
                row_next   = '0;
                col_next   = '0;
                lat_next   = '0;
            end
        endcase
    end

    // Operand registers change only on an accepted element; they keep their
    // contents across holds, voided frames and idle gaps.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_vector <= '0;
            matrix    <= '0;
        end else if (accept) begin
            if (state == LOAD_VEC) begin
                in_vector[vidx] <= s_data;
            end else if (state == LOAD_MAT) begin
                matrix[row][col] <= s_data;
            end
        end
    end

endmodule

// File: tb/tb_mv_operand_loader.sv
// tb_mv_operand_loader: directed scenarios for the operand loader with SIZE=2,
// LATENCY=3. Expected operand sets are queued when a frame is driven and
// compared by a monitor whenever the loader issues its capture strobe.
module tb_mv_operand_loader;

    localparam int WIDTH   = 8;
    localparam int SIZE    = 2;
    localparam int LATENCY = 3;

    logic                                 clk = 1'b0;
    logic                                 rst;
    logic                                 s_valid;
    logic                                 s_ready;
    logic [WIDTH-1:0]                     s_data;
    logic                                 s_last;
    logic [SIZE-1:0][WIDTH-1:0]           in_vector;
    logic [SIZE-1:0][SIZE-1:0][WIDTH-1:0] matrix;
    logic                                 op_valid;
    logic                                 res_strobe;
    logic                                 frame_err;

    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    int          strobe_count = 0;
    int          strobe_cyc[$];
    logic [47:0] exp_q[$];

    mv_operand_loader #(
        .WIDTH  (WIDTH),
        .SIZE   (SIZE),
        .LATENCY(LATENCY)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_data    (s_data),
        .s_last    (s_last),
        .in_vector (in_vector),
        .matrix    (matrix),
        .op_valid  (op_valid),
        .res_strobe(res_strobe),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_output(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Reference packing: vector element j and matrix[r][c] = frame element 2+2r+c.
    function automatic logic [47:0] pack_ops(input logic [7:0] e [6]);
        logic [SIZE-1:0][WIDTH-1:0]           v;
        logic [SIZE-1:0][SIZE-1:0][WIDTH-1:0] m;
        for (int j = 0; j < SIZE; j++) v[j] = e[j];
        for (int r = 0; r < SIZE; r++)
            for (int c = 0; c < SIZE; c++)
                m[r][c] = e[SIZE + r * SIZE + c];
        return {v, m};
    endfunction

    // Capture strobe: pop the scoreboard and compare the presented operands.
    always @(negedge clk) begin
        if (!rst) begin
            if (res_strobe) begin
                strobe_count++;
                strobe_cyc.push_back(cyc);
                if (exp_q.size() == 0) begin
                    check_output("unexpected_strobe", 64'd1, 64'd0);
                end else begin
                    check_output("strobe_operands", 64'({in_vector, matrix}), 64'(exp_q.pop_front()));
                end
            end
            if (frame_err) check_output("err_exclusive", 64'({op_valid, res_strobe}), 64'd0);
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Present one element and wait (bounded) until the loader accepts it.
    task automatic apply_stimulus(input logic [7:0] d, input logic last);
        bit ok;
        ok = 1'b0;
        s_valid = 1'b1;
        s_data  = d;
        s_last  = last;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (s_ready) begin
                @(posedge clk);
                #1;
                ok = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        check_output("accept", 64'(ok), 64'd1);
    endtask

    // Idle cycles with garbage on data/last, which must be ignored.
    task automatic idle(input int n);
        s_valid = 1'b0;
        s_data  = 8'($urandom);
        s_last  = 1'($urandom);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        logic [7:0] fr [6];
        logic [7:0] fb [6];
        int op_high, not_ready, strobe_at, base, cyc_a, cyc_b;

        rst = 1'b1;
        s_valid = 1'b0;
        s_data = '0;
        s_last = 1'b0;
        @(negedge clk);
        check_output("reset_s_ready", 64'(s_ready), 64'd1);
        check_output("reset_op_valid", 64'(op_valid), 64'd0);
        check_output("reset_res_strobe", 64'(res_strobe), 64'd0);
        check_output("reset_frame_err", 64'(frame_err), 64'd0);
        check_output("reset_operands", 64'({in_vector, matrix}), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(2);

        // Nominal frame.
        $display("[TB] nominal frame");
        fr = '{8'd1, 8'd2, 8'(-3), 8'd4, 8'd5, 8'(-6)};
        exp_q.push_back(pack_ops(fr));
        base = strobe_count;
        for (int k = 0; k < 6; k++) apply_stimulus(fr[k], k == 5);
        s_valid = 1'b0;
        op_high = 0;
        not_ready = 0;
        strobe_at = -1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (op_valid) op_high++;
            if (!s_ready) not_ready++;
            if (res_strobe) strobe_at = c;
            @(posedge clk);
            #1;
        end
        check_output("nominal_op_valid_cycles", 64'(op_high), 64'd3);
        check_output("nominal_not_ready_cycles", 64'(not_ready), 64'd3);
        check_output("nominal_strobe_cycle", 64'(strobe_at), 64'd2);
        check_output("nominal_strobe_count", 64'(strobe_count - base), 64'd1);

        // Same frame with stalls after elements 2 and 4.
        $display("[TB] stalled frame");
        fr = '{8'd1, 8'd2, 8'(-3), 8'd4, 8'd5, 8'(-6)};
        exp_q.push_back(pack_ops(fr));
        for (int k = 0; k < 6; k++) begin
            apply_stimulus(fr[k], k == 5);
            if (k == 1 || k == 3) idle(2);
            if (k == 4) check_output("stall_op_valid_before_last", 64'(op_valid), 64'd0);
        end
        s_valid = 1'b0;
        @(negedge clk);
        check_output("stall_op_valid_rise", 64'(op_valid), 64'd1);
        @(posedge clk);
        #1;
        idle(4);

        // Early s_last on element 4, then a clean frame.
        $display("[TB] early s_last");
        fr = '{8'd1, 8'd2, 8'(-3), 8'd4, 8'd0, 8'd0};
        for (int k = 0; k < 4; k++) apply_stimulus(fr[k], k == 3);
        s_valid = 1'b0;
        @(negedge clk);
        check_output("early_frame_err", 64'(frame_err), 64'd1);
        check_output("early_s_ready", 64'(s_ready), 64'd1);
        @(posedge clk);
        #1;
        @(negedge clk);
        check_output("early_err_single_pulse", 64'(frame_err), 64'd0);
        check_output("early_no_hold", 64'(op_valid), 64'd0);
        @(posedge clk);
        #1;
        fr = '{8'd7, 8'd8, 8'd9, 8'd10, 8'd11, 8'd12};
        exp_q.push_back(pack_ops(fr));
        base = strobe_count;
        for (int k = 0; k < 6; k++) apply_stimulus(fr[k], k == 5);
        idle(5);
        check_output("recover_strobe_count", 64'(strobe_count - base), 64'd1);

        // Missing s_last: frame is voided, written elements remain.
        $display("[TB] missing s_last");
        fr = '{8'd31, 8'd32, 8'd33, 8'd34, 8'd35, 8'd36};
        base = strobe_count;
        for (int k = 0; k < 6; k++) apply_stimulus(fr[k], 1'b0);
        s_valid = 1'b0;
        @(negedge clk);
        check_output("missing_frame_err", 64'(frame_err), 64'd1);
        check_output("missing_s_ready", 64'(s_ready), 64'd1);
        @(posedge clk);
        #1;
        idle(4);
        check_output("missing_no_hold", 64'(op_valid), 64'd0);
        check_output("missing_no_strobe", 64'(strobe_count - base), 64'd0);
        check_output("missing_operands_kept", 64'({in_vector, matrix}), 64'(pack_ops(fr)));

        // Reset during the second hold cycle.
        $display("[TB] reset mid-hold");
        fr = '{8'd40, 8'd41, 8'd42, 8'd43, 8'd44, 8'd45};
        base = strobe_count;
        for (int k = 0; k < 6; k++) apply_stimulus(fr[k], k == 5);
        s_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check_output("rst_op_valid", 64'(op_valid), 64'd0);
        check_output("rst_res_strobe", 64'(res_strobe), 64'd0);
        check_output("rst_frame_err", 64'(frame_err), 64'd0);
        check_output("rst_operands", 64'({in_vector, matrix}), 64'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_output("rst_s_ready_after", 64'(s_ready), 64'd1);
        @(posedge clk);
        #1;
        idle(5);
        check_output("rst_no_strobe", 64'(strobe_count - base), 64'd0);

        // Back-to-back frames with extreme values.
        $display("[TB] back-to-back frames");
        fr = '{8'h80, 8'h7F, 8'h7F, 8'h80, 8'h01, 8'hFF};
        fb = '{8'h7F, 8'h80, 8'h80, 8'h7F, 8'hFF, 8'h01};
        exp_q.push_back(pack_ops(fr));
        exp_q.push_back(pack_ops(fb));
        base = strobe_count;
        for (int k = 0; k < 6; k++) apply_stimulus(fr[k], k == 5);
        cyc_a = cyc;
        apply_stimulus(fb[0], 1'b0);
        cyc_b = cyc;
        check_output("b2b_first_accept_gap", 64'(cyc_b - cyc_a), 64'd4);
        for (int k = 1; k < 6; k++) apply_stimulus(fb[k], k == 5);
        idle(6);
        check_output("b2b_strobe_count", 64'(strobe_count - base), 64'd2);
        if (strobe_cyc.size() >= 2)
            check_output("b2b_strobe_spacing",
                         64'(strobe_cyc[strobe_cyc.size() - 1] - strobe_cyc[strobe_cyc.size() - 2]), 64'd9);
        check_output("b2b_extremes_kept", 64'({in_vector, matrix}), 64'(pack_ops(fb)));

        check_output("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
